// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous signal in clk_in cycles,
// with range-based lock detection and a sticky stop (timeout) flag.
module clk_period_meter #(
    parameter int                 CNT_W    = 16,
    parameter logic [CNT_W-1:0]   TIMEOUT  = 16'hFFF0,
    parameter logic [CNT_W-1:0]   MIN_PER  = 16'd90,
    parameter logic [CNT_W-1:0]   MAX_PER  = 16'd110,
    parameter int                 LOCK_CNT = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        STALL
    } state_e;

    localparam logic [3:0]       LOCK_V   = 4'(LOCK_CNT);
    localparam logic [CNT_W-1:0] TMO_LAST = TIMEOUT - 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [3:0]       good_q, good_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             lock_q, lock_d;
    logic             tmo_q, tmo_d;

    logic             rise, fall;
    logic [CNT_W-1:0] cnt_p1;
    logic             in_range;

    assign rise     = s2_q & ~s3_q;
    assign fall     = ~s2_q & s3_q;
    assign cnt_p1   = cnt_q + 1'b1;
    assign in_range = (cnt_p1 >= MIN_PER) && (cnt_p1 <= MAX_PER);

    // Synchronizer and edge-detect flops are left alone by clear
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            good_q  <= '0;
            per_q   <= '0;
            high_q  <= '0;
            valid_q <= 1'b0;
            lock_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            good_q  <= good_d;
            per_q   <= per_d;
            high_q  <= high_d;
            valid_q <= valid_d;
            lock_q  <= lock_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = rise ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_p1);
        hold_d  = hold_q;
        good_d  = good_q;
        per_d   = per_q;
        high_d  = high_q;
        valid_d = 1'b0;
        lock_d  = lock_q;
        tmo_d   = tmo_q;

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (fall) begin
                    hold_d = cnt_p1;
                end
                if (rise) begin
                    per_d   = cnt_p1;
                    high_d  = hold_q;
                    valid_d = 1'b1;
                    if (in_range) begin
                        good_d = (good_q == LOCK_V) ? good_q : good_q + 4'd1;
                    end else begin
                        good_d = 4'd0;
                    end
                    lock_d = (good_d == LOCK_V);
                end else if (cnt_q == TMO_LAST) begin
                    state_d = STALL;
                    tmo_d   = 1'b1;
                    good_d  = 4'd0;
                    lock_d  = 1'b0;
                end
            end
            STALL: begin
                good_d = 4'd0;
                lock_d = 1'b0;
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            hold_d  = '0;
            good_d  = 4'd0;
            per_d   = '0;
            high_d  = '0;
            valid_d = 1'b0;
            lock_d  = 1'b0;
            tmo_d   = 1'b0;
        end
    end

    assign period       = per_q;
    assign high_time    = high_q;
    assign period_valid = valid_q;
    assign locked       = lock_q;
    assign timeout      = tmo_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: stimulus queues expected
// measurements, a negedge monitor pops them on each period_valid.
module tb_clk_period_meter;

    localparam int TMO  = 500;
    localparam int MINP = 90;
    localparam int MAXP = 110;
    localparam int LOCK = 4;

    typedef struct {
        logic [15:0] per;
        logic [15:0] hi;
        logic        lk;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sig_in = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] period;
    logic [15:0] high_time;
    logic        period_valid;
    logic        locked;
    logic        timeout;

    int   errors = 0;
    int   checks = 0;
    int   cyc_n = 0;
    int   good = 0;
    bit   started = 0;
    int   last_p = 0;
    int   last_h = 0;
    int   rise_cyc = 0;
    exp_t exp_q[$];

    clk_period_meter #(
        .CNT_W   (16),
        .TIMEOUT (16'(TMO)),
        .MIN_PER (16'(MINP)),
        .MAX_PER (16'(MAXP)),
        .LOCK_CNT(LOCK)
    ) dut (
        .clk_in      (clk),
        .reset       (reset),
        .sig_in      (sig_in),
        .clear       (clear),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .locked      (locked),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n = cyc_n + 1;

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, req, cyc_n);
        end
    endtask

    task automatic push_exp(input int p, input int h);
        exp_t e;
        if (p >= MINP && p <= MAXP) begin
            good = (good < LOCK) ? good + 1 : good;
        end else begin
            good = 0;
        end
        e.per = 16'(p);
        e.hi  = 16'(h);
        e.lk  = (good == LOCK);
        exp_q.push_back(e);
    endtask

    // One full high/low cycle; transitions land ph ns after a rising clock edge
    task automatic cyc(input int h, input int l, input int ph);
        if (started) push_exp(last_p, last_h);
        started  = 1;
        last_h   = h;
        last_p   = h + l;
        rise_cyc = cyc_n;
        sig_in   = 1'b1;
        repeat (h) @(posedge clk);
        #ph;
        sig_in = 1'b0;
        repeat (l) @(posedge clk);
        #ph;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_high"}, int'(high_time), 0);
        chk({tag, "_valid"}, int'(period_valid), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset && period_valid) begin
            if (exp_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_valid: got period %0d expected none",
                         period);
            end else begin
                e = exp_q.pop_front();
                chk("period", int'(period), int'(e.per));
                chk("high_time", int'(high_time), int'(e.hi));
                chk("locked", int'(locked), int'(e.lk));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int jt[9][3];
        jt = '{'{51, 50, 3}, '{50, 52, 7}, '{52, 51, 2},
               '{51, 51, 9}, '{50, 51, 4}, '{52, 50, 6},
               '{51, 52, 1}, '{51, 51, 5}, '{50, 52, 8}};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 1: steady 51/51, lock on 4th valid
        repeat (6) cyc(51, 51, 1);

        // 2: one 40/40 period drops lock, relock after four 102s
        cyc(40, 40, 1);
        repeat (5) cyc(51, 51, 1);

        // 3: signal stops -> timeout exactly TMO cycles after rise-detect
        while (cyc_n < rise_cyc + 2 + TMO) begin
            @(posedge clk);
            #1;
        end
        chk("timeout_before", int'(timeout), 0);
        @(posedge clk);
        #1;
        chk("timeout_at", int'(timeout), 1);
        chk("timeout_unlock", int'(locked), 0);
        started = 0;
        good    = 0;
        repeat (3) cyc(51, 51, 1);
        chk("timeout_sticky", int'(timeout), 1);

        // 4: clear mid-period
        cyc(51, 20, 1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk_zero("clear");
        started = 0;
        good    = 0;
        repeat (30) @(posedge clk);
        #1;
        repeat (6) cyc(51, 51, 1);

        // 5: asynchronous reset between edges
        cyc(51, 20, 1);
        #3;
        reset = 1'b0;
        #1;
        chk_zero("areset");
        started = 0;
        good    = 0;
        repeat (4) @(posedge clk);
        #4;
        reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        repeat (6) cyc(51, 51, 1);

        // 6: sub-cycle phase and +/-1 cycle jitter
        for (int i = 0; i < 9; i++) cyc(jt[i][0], jt[i][1], jt[i][2]);

        // final rise flushes the last period
        push_exp(last_p, last_h);
        sig_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
